bvneg_sgt_checker: RTL and testbench
====================================

BVNEG_SGT_CHECKER -- requirements
Module: bvneg_sgt_checker

Interface
REQ-001 SHALL have parameter W, default 4, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  candidate pair (x, t) offered.
REQ-005 SHALL have port in_ready  output  1  block can accept a pair.
REQ-006 SHALL have port in_x  input  W  candidate witness x.
REQ-007 SHALL have port in_t  input  W  bound t.
REQ-008 SHALL have port out_valid  output  1  verdict available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the verdict.
REQ-010 SHALL have port out_sat  output  1  1 iff (-x mod 2^W) >s t, with signed two's complement.
REQ-011 SHALL have port out_negx  output  W  computed -x mod 2^W.

Function
REQ-012 SHALL evaluate the witness condition bvsgt(bvneg(x), t) bit-serially, LSB first, one bit per cycle.
REQ-013 SHALL implement three states: IDLE, SHIFT and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 IDLE: on in_valid & in_ready, SHALL latch x and t, clear the bit index, set carry=1 and gt=0, and go to SHIFT.
REQ-015 SHIFT, bit i: SHALL compute n_i = ~x_i XOR carry and carry' = ~x_i & carry, and shift n_i into the negx register.
REQ-016 SHIFT, bits i < W-1: if n_i != t_i, SHALL set gt = n_i; if equal, gt SHALL hold.
REQ-017 SHIFT, bit W-1 (sign bit): if n_i != t_i, SHALL set gt = ~n_i; if equal, gt SHALL hold; then go to DONE.
REQ-018 Latency: handshake in cycle 0, SHIFT during cycles 1..W, out_valid high from cycle W+1.
REQ-019 DONE: out_sat and out_negx SHALL hold stable until out_valid & out_ready, then go to IDLE on the next edge.
REQ-020 SHALL not accept input while in SHIFT or DONE; in_x and in_t SHALL be ignored outside the IDLE handshake.
REQ-021 x = 100..0: -x SHALL equal x (wrap-around, carry ignored), and the comparison SHALL use that value.
REQ-022 x = 0: -x SHALL be 0, and out_sat SHALL equal (t <s 0).
REQ-023 Peak throughput SHALL be one verdict per W+2 cycles with out_ready held high.

Reset
REQ-024 On rst=1 at a clock edge, state SHALL become IDLE and out_valid SHALL be 0; in_ready SHALL be 1 after the next edge.
REQ-025 Reset values: out_sat=0, out_negx=0, carry=1, gt=0, bit index=0.
REQ-026 Reset during SHIFT or DONE SHALL abort the transaction with no verdict emitted; rst SHALL take priority over the handshakes.

Configuration
REQ-027 Macro BVNEG_SGT_CHECKER_STATS_EN SHALL control the statistics feature.
REQ-028 With BVNEG_SGT_CHECKER_STATS_EN defined, SHALL add outputs pass_cnt and fail_cnt, each 16 bits.
REQ-029 Counter behaviour: increment on each accepted verdict with out_sat=1 or 0 respectively, saturate at 16'hFFFF, clear on rst.
REQ-030 Without BVNEG_SGT_CHECKER_STATS_EN, the counter ports and registers SHALL be absent; all other behaviour SHALL be identical.

Verification (W=4)
REQ-031 x=0001, t=0000 -> out_negx=1111, out_sat=0, out_valid rises exactly 5 cycles after the handshake.
REQ-032 x=1111, t=0000 -> out_negx=0001, out_sat=1; x=0011, t=1000 -> out_negx=1101, out_sat=1.
REQ-033 x=1000, t=1111 -> out_negx=1000, out_sat=0 (wrap case); x=0000, t=1111 -> out_sat=1.
REQ-034 out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored; release -> IDLE on the next edge.
REQ-035 rst pulsed in the 2nd SHIFT cycle -> no out_valid; the next pair x=1111, t=0000 yields out_sat=1.
REQ-036 With STATS_EN, 3 passing plus 2 failing verdicts -> pass_cnt=3, fail_cnt=2; rst -> both 0.

Source files
------------

// File: rtl/bvneg_sgt_checker.sv
// ---------------------------------------------------------------------------
// bvneg_sgt_checker
//
// Bit-serial checker for the witness condition bvsgt(bvneg(x), t):
// out_sat = 1 iff (-x mod 2^W) >s t in signed two's complement.
// One bit is processed per clock, LSB first. A pair is taken in IDLE,
// shifted through during W SHIFT cycles, and the verdict is held in DONE
// until the consumer accepts it.
//
// Parameters
//   W          operand width in bits (2..32), default 4
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   candidate pair (in_x, in_t) offered
//   in_ready   block is idle and can accept a pair
//   in_x       candidate witness x
//   in_t       bound t
//   out_valid  verdict available (state DONE)
//   out_ready  consumer accepts the verdict
//   out_sat    1 iff (-x) >s t
//   out_negx   computed -x mod 2^W
//   pass_cnt   (stats build only) saturating count of accepted out_sat=1
//   fail_cnt   (stats build only) saturating count of accepted out_sat=0
//
// Configuration macro
//   BVNEG_SGT_CHECKER_STATS_EN  adds the pass_cnt / fail_cnt outputs
// ---------------------------------------------------------------------------
module bvneg_sgt_checker #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_t,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_sat,
  output logic [W-1:0] out_negx
`ifdef BVNEG_SGT_CHECKER_STATS_EN
  ,
  output logic [15:0]  pass_cnt,
  output logic [15:0]  fail_cnt
`endif
);

  localparam int IW = $clog2(W);
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   t_q, t_d;
  logic [W-1:0]   negx_q, negx_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic           gt_q, gt_d;

  // Current negated bit and its carry; x_q/t_q are shifted right so bit 0
  // is always the bit under evaluation.
  logic           n_bit;
  logic           carry_next;

  // Next-state and datapath update for the serial negate-and-compare.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    t_d        = t_q;
    negx_d     = negx_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    gt_d       = gt_q;
    // -x = ~x + 1, rippled LSB first with the carry seeded to 1.
    n_bit      = (~x_q[0]) ^ carry_q;
    carry_next = (~x_q[0]) & carry_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d     = in_x;
          t_d     = in_t;
          idx_d   = '0;
          carry_d = 1'b1;
          gt_d    = 1'b0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        negx_d  = {n_bit, negx_q[W-1:1]};
        x_d     = {1'b0, x_q[W-1:1]};
        t_d     = {1'b0, t_q[W-1:1]};
        carry_d = carry_next;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          // Sign bit: a set sign bit means the smaller signed value, so the
          // sense of the comparison is inverted here.
          if (n_bit != t_q[0]) begin
            gt_d = ~n_bit;
          end else begin
            gt_d = gt_q;
          end
          state_d = ST_DONE;
        end else begin
          // A higher differing bit overrides anything decided below it.
          if (n_bit != t_q[0]) begin
            gt_d = n_bit;
          end else begin
            gt_d = gt_q;
          end
          state_d = ST_SHIFT;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      t_q     <= '0;
      negx_q  <= '0;
      idx_q   <= '0;
      carry_q <= 1'b1;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      t_q     <= t_d;
      negx_q  <= negx_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      gt_q    <= gt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  // gt_q and negx_q are frozen in DONE, so they serve directly as the verdict.
  assign out_sat   = gt_q;
  assign out_negx  = negx_q;

`ifdef BVNEG_SGT_CHECKER_STATS_EN
  logic [15:0] pass_cnt_q, pass_cnt_d;
  logic [15:0] fail_cnt_q, fail_cnt_d;
  logic        verdict_accept;

  // Saturating pass/fail counters, stepped on each accepted verdict.
  always_comb begin
    pass_cnt_d     = pass_cnt_q;
    fail_cnt_d     = fail_cnt_q;
    verdict_accept = (state_q == ST_DONE) && out_ready;
    if (verdict_accept && gt_q && (pass_cnt_q != 16'hFFFF)) begin
      pass_cnt_d = pass_cnt_q + 16'd1;
    end else begin
      pass_cnt_d = pass_cnt_q;
    end
    if (verdict_accept && !gt_q && (fail_cnt_q != 16'hFFFF)) begin
      fail_cnt_d = fail_cnt_q + 16'd1;
    end else begin
      fail_cnt_d = fail_cnt_q;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_cnt_q <= 16'd0;
      fail_cnt_q <= 16'd0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
`endif

endmodule

// File: tb/tb_bvneg_sgt_checker.sv
// ---------------------------------------------------------------------------
// tb_bvneg_sgt_checker
//
// Directed bench for bvneg_sgt_checker at W=4. Expected negations and
// verdicts are hand-computed constants. Inputs are driven and outputs
// sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_bvneg_sgt_checker;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_x;
  logic [W-1:0] in_t;
  logic         out_valid;
  logic         out_ready;
  logic         out_sat;
  logic [W-1:0] out_negx;
`ifdef BVNEG_SGT_CHECKER_STATS_EN
  logic [15:0]  pass_cnt;
  logic [15:0]  fail_cnt;
`endif

  int total_cnt = 0;
  int bad_cnt   = 0;

  bvneg_sgt_checker #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_t      (in_t),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sat   (out_sat),
    .out_negx  (out_negx)
`ifdef BVNEG_SGT_CHECKER_STATS_EN
    ,
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one pair from IDLE; returns in the first SHIFT cycle.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] t);
    check_val("ready_before_send", {31'd0, in_ready}, 32'd1);
    in_x     = x;
    in_t     = t;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_x     = 4'b1010;
    in_t     = 4'b0101;
  endtask

  // n counts cycles after the handshake; the handshake cycle is 0.
  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_val("idle_after_accept", {31'd0, in_ready}, 32'd1);
    check_val("valid_low_after_accept", {31'd0, out_valid}, 32'd0);
  endtask

  logic [W-1:0] vx   [10] = '{4'b0001, 4'b1111, 4'b0011, 4'b1000, 4'b0000,
                              4'b0101, 4'b0110, 4'b0111, 4'b1110, 4'b0000};
  logic [W-1:0] vt   [10] = '{4'b0000, 4'b0000, 4'b1000, 4'b1111, 4'b1111,
                              4'b0010, 4'b1001, 4'b1001, 4'b0001, 4'b0000};
  logic [W-1:0] vneg [10] = '{4'b1111, 4'b0001, 4'b1101, 4'b1000, 4'b0000,
                              4'b1011, 4'b1010, 4'b1001, 4'b0010, 4'b0000};
  logic         vsat [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                              1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    int n;
    int c;
    int first_c;
    int second_c;
    logic seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_t      = '0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_val("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("reset_out_sat", {31'd0, out_sat}, 32'd0);
    check_val("reset_out_negx", {28'd0, out_negx}, 32'd0);

    // Directed vectors: latency, negation and verdict.
    for (int i = 0; i < 10; i++) begin
      send(vx[i], vt[i]);
      wait_valid(n);
      check_val("latency", n, 32'd5);
      check_val("negx", {28'd0, out_negx}, {28'd0, vneg[i]});
      check_val("sat", {31'd0, out_sat}, {31'd0, vsat[i]});
      accept();
    end

    // Back-pressure: verdict held for 10 cycles, new input ignored.
    send(4'b0011, 4'b1000);
    wait_valid(n);
    in_valid = 1'b1;
    in_x     = 4'b0001;
    in_t     = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      check_val("stall_valid", {31'd0, out_valid}, 32'd1);
      check_val("stall_ready", {31'd0, in_ready}, 32'd0);
      check_val("stall_negx", {28'd0, out_negx}, 32'hD);
      check_val("stall_sat", {31'd0, out_sat}, 32'd1);
      step();
    end
    in_valid = 1'b0;
    accept();

    // Peak throughput: verdicts every W+2 cycles with both sides always ready.
    in_valid  = 1'b1;
    in_x      = 4'b1111;
    in_t      = 4'b0000;
    out_ready = 1'b1;
    c = 0;
    first_c = -1;
    second_c = -1;
    while (second_c < 0 && c < 40) begin
      step();
      c++;
      if (out_valid) begin
        check_val("thru_sat", {31'd0, out_sat}, 32'd1);
        if (first_c < 0) begin
          first_c = c;
        end else begin
          second_c = c;
          in_valid = 1'b0;
        end
      end
    end
    check_val("thru_period", second_c - first_c, 32'd6);
    step();
    out_ready = 1'b0;
    check_val("thru_idle", {31'd0, in_ready}, 32'd1);

    // Reset in the 2nd SHIFT cycle aborts the transaction.
    send(4'b0101, 4'b0010);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("abort_negx", {28'd0, out_negx}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    check_val("abort_no_verdict", {31'd0, seen}, 32'd0);
    send(4'b1111, 4'b0000);
    wait_valid(n);
    check_val("post_abort_latency", n, 32'd5);
    check_val("post_abort_negx", {28'd0, out_negx}, 32'h1);
    check_val("post_abort_sat", {31'd0, out_sat}, 32'd1);
    accept();

`ifdef BVNEG_SGT_CHECKER_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("stats_clear_pass", {16'd0, pass_cnt}, 32'd0);
    check_val("stats_clear_fail", {16'd0, fail_cnt}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      send(vx[i], vt[i]);
      wait_valid(n);
      accept();
    end
    check_val("stats_pass", {16'd0, pass_cnt}, 32'd3);
    check_val("stats_fail", {16'd0, fail_cnt}, 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("stats_rst_pass", {16'd0, pass_cnt}, 32'd0);
    check_val("stats_rst_fail", {16'd0, fail_cnt}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
